// File: rtl/sensor_input_conditioner.sv
// Synchronises and debounces six sensor switches and two active-low buttons.
// Ports: clock, reset_n (async low), raw_* inputs; debounced levels, pulse_2/3, sensor_changed.
module sensor_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw_low_water_level,
  input  logic raw_mid_water_level,
  input  logic raw_high_water_level,
  input  logic raw_earth_humidity,
  input  logic raw_air_humidity,
  input  logic raw_low_temperature,
  input  logic raw_button_2_n,
  input  logic raw_button_3_n,
  output logic low_water_level,
  output logic mid_water_level,
  output logic high_water_level,
  output logic earth_humidity,
  output logic air_humidity,
  output logic low_temperature,
  output logic pulse_2,
  output logic pulse_3,
  output logic sensor_changed
);

  localparam logic [COUNT_WIDTH-1:0] LAST =
    COUNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  // Channels 0..5 are sensors, 6..7 are buttons (inverted: 1 = pressed).
  logic [7:0] raw;
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;
  logic [7:0] stable_q;
  logic [7:0] stable_d;
  logic [7:0] prev_q;
  logic [1:0] pulse_q;
  logic       changed_q;
  logic [COUNT_WIDTH-1:0] cnt_q [8];
  logic [COUNT_WIDTH-1:0] cnt_d [8];

  assign raw = {~raw_button_3_n, ~raw_button_2_n,
                raw_low_temperature, raw_air_humidity,
                raw_earth_humidity, raw_high_water_level,
                raw_mid_water_level, raw_low_water_level};

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      prev_q    <= '0;
      pulse_q   <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      // prev_q lags stable_q by one edge, so both strobes
      // appear the cycle after the stable register moves.
      prev_q    <= stable_q;
      pulse_q   <= stable_q[7:6] & ~prev_q[7:6];
      changed_q <= |(stable_q[5:0] ^ prev_q[5:0]);
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign low_water_level  = stable_q[0];
  assign mid_water_level  = stable_q[1];
  assign high_water_level = stable_q[2];
  assign earth_humidity   = stable_q[3];
  assign air_humidity     = stable_q[4];
  assign low_temperature  = stable_q[5];
  assign pulse_2          = pulse_q[0];
  assign pulse_3          = pulse_q[1];
  assign sensor_changed   = changed_q;

endmodule

// File: doc/sensor_input_conditioner.md
Name: sensor_input_conditioner

Overview:
- Front-end that produces the clean sensor levels and operator pulses consumed by the irrigation top level.
- Takes raw, asynchronous, bouncy board inputs:
  - three water-level switches;
  - earth humidity, air humidity and low-temperature switches;
  - two active-low push buttons.
- Synchronises and debounces every input.
- Emits stable levels, single-cycle button pulses (feeding pulse_2 and pulse_3) and a one-cycle "sensor changed" strobe.

Parameters:
- DEBOUNCE_CYCLES, default 50000: number of consecutive clock cycles a synchronised input must differ from its stable value before the stable value updates. Legal range is 2 or more.
- COUNT_WIDTH, default 16: width of each per-channel debounce counter. Must satisfy 2^COUNT_WIDTH >= DEBOUNCE_CYCLES.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- raw_low_water_level  input  1  asynchronous switch, 1 = water present.
- raw_mid_water_level  input  1  asynchronous switch, 1 = water present.
- raw_high_water_level  input  1  asynchronous switch, 1 = water present.
- raw_earth_humidity  input  1  asynchronous switch, 1 = humid.
- raw_air_humidity  input  1  asynchronous switch, 1 = humid.
- raw_low_temperature  input  1  asynchronous switch, 1 = cold.
- raw_button_2_n  input  1  push button, 0 = pressed.
- raw_button_3_n  input  1  push button, 0 = pressed.
- low_water_level, mid_water_level, high_water_level  output  1 each  debounced levels.
- earth_humidity, air_humidity, low_temperature  output  1 each  debounced levels.
- pulse_2, pulse_3  output  1 each  one-cycle high pulse on each debounced press.
- sensor_changed  output  1  one-cycle high when any of the six sensor outputs changes.

Behaviour:
- Channels: 8 identical channels (6 sensors, 2 buttons). Each channel has:
  - a two-flop synchroniser (sync1 -> sync2);
  - a COUNT_WIDTH-bit counter;
  - a stable register.
- Button polarity: button channels invert before the synchroniser, so internally 1 = pressed.
- Reset (reset_n low, asynchronous, effective immediately):
  - all synchroniser flops, counters and stable registers are 0;
  - all outputs are 0 (levels 0, pulses 0, sensor_changed 0);
  - reset has priority over every other event.
- Reset release: sampling resumes on the first rising edge with reset_n high. A raw input that was already 1 during reset is treated as a change and debounced normally.
- Debounce rule, evaluated each edge per channel:
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
- Latency: the stable output changes exactly DEBOUNCE_CYCLES+2 rising edges after the edge that first samples the new raw value, provided the raw value holds throughout.
- Glitch rejection: a raw excursion that returns before the update edge clears the counter on the first matching cycle, and the output does not change. Counting restarts from 0 on the next excursion; there is no partial credit.
- Button pulses:
  - pulse_x is high for exactly one cycle, on the cycle after the button's stable value goes 0 -> 1.
  - A stable 1 -> 0 transition (release) produces nothing.
  - Holding the button produces no repeat pulses.
  - The two buttons are fully independent; simultaneous presses give simultaneous pulses.
- sensor_changed: registered. It is high for one cycle, the cycle after any of the six sensor stable registers updates, in either direction. Several sensors updating on the same edge give a single pulse; button channels never assert it.
- No cross-checking of water levels is done here. Conflicting combinations, e.g. high=1 and low=0, pass through unchanged to the downstream checker.
- Counter saturation: the counter never exceeds DEBOUNCE_CYCLES-1. It cannot wrap.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
1. Reset with all raw sensors 1 and buttons released -> all outputs 0 during reset; after release, the six levels rise together on edge 6 and sensor_changed is high for one cycle on edge 7.
2. raw_mid_water_level 0->1 held -> mid_water_level rises exactly 6 edges after first sampling.
3. raw_air_humidity pulsed high for 3 cycles, low for 1, then high -> no output change until 6 edges after the final rise; sensor_changed pulses exactly once.
4. raw_button_3_n low for 20 cycles with 2-cycle bounces at press and release -> exactly one pulse_3, one cycle wide; pulse_2 stays 0 throughout.
5. Both buttons pressed on the same edge -> pulse_2 and pulse_3 are high on the same single cycle.
6. reset_n asserted mid-count (counter=2) while raw_high_water_level=1 -> the output stays 0 and the counter clears asynchronously; after release, the full 6-edge latency applies.
